uart_tx_param: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 FIFO-driven transmitter. It takes one data word per valid/ready handshake and serialises it LSB-first on TXD. Data width, parity, stop-bit count and baud divisor are all configurable. It sits between a byte source (FIFO or packet builder) and the board TX pin. The line idles high.

---
 rtl/uart_tx_param.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter. One character per valid/ready
// handshake, sent LSB first as start / DATA_BITS data / optional parity /
// STOP_BITS stop bits, each bit CLK_DIV clocks long. The line idles high.
// Optional packet framing (header HDR_CMD,~HDR_CMD before a packet, trailer
// ~HDR_CMD,HDR_CMD after the DATA_LAST character) is built when the macro
// UART_TX_FRAME_EN is defined.
module uart_tx_param #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned CLK_DIV   = 78,
    parameter logic [7:0]  HDR_CMD   = 8'h01
) (
    input  logic                 SYS_CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 DATA_VALID,
    input  logic                 DATA_LAST,
    output logic                 DATA_READY,
    output logic                 TXD,
    output logic                 BUSY
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..8");
        end
        if (PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
            $error("uart_tx_param: CLK_DIV must be 2..65535");
        end
    endgenerate

`ifdef UART_TX_FRAME_EN
    // HDR and TRL are the start bits of header and trailer characters; the
    // data, parity and stop bits of those characters reuse DATA/PAR/STOP.
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, HDR, TRL} state_t;
    typedef enum logic [1:0] {K_DATA, K_HDR, K_TRL} kind_t;
    localparam logic [DATA_BITS-1:0] HDR_A = HDR_CMD[DATA_BITS-1:0];
    localparam logic [DATA_BITS-1:0] HDR_B = ~HDR_A;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    state_t                 state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   rdy_en_q;
    logic                   bit_end, last_stop_end, frame_open, accept;

`ifdef UART_TX_FRAME_EN
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   last_q, last_d;
    kind_t                  kind_q, kind_d;
    logic                   idx_q, idx_d;
    assign frame_open = (kind_q == K_DATA) && !last_q;
`else
    logic unused_frame;
    assign unused_frame = ^{DATA_LAST, HDR_CMD};
    assign frame_open   = 1'b1;
`endif

    assign bit_end       = (baud_q == BAUD_LAST);
    assign last_stop_end = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);
    assign DATA_READY    = rdy_en_q && ((state_q == IDLE) || (last_stop_end && frame_open));
    assign accept        = DATA_VALID && DATA_READY;
    assign BUSY          = (state_q != IDLE);
    assign TXD           = txd_q;

    // Next-state logic: bit sequencing, character loading and registered line value.
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        par_d   = par_q;
`ifdef UART_TX_FRAME_EN
        hold_d  = hold_q;
        last_d  = last_q;
        kind_d  = kind_q;
        idx_d   = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef UART_TX_FRAME_EN
                    hold_d  = DATA_IN;
                    last_d  = DATA_LAST;
                    kind_d  = K_HDR;
                    idx_d   = 1'b0;
                    sh_d    = HDR_A;
                    par_d   = par_bit(HDR_A);
                    state_d = HDR;
`else
                    sh_d    = DATA_IN;
                    par_d   = par_bit(DATA_IN);
                    state_d = START;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
`ifdef UART_TX_FRAME_EN
            HDR, TRL: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
`endif
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q != STOP_LAST) begin
                        stop_d = 1'b1;
                    end else begin
`ifdef UART_TX_FRAME_EN
                        case (kind_q)
                            K_HDR: begin
                                if (!idx_q) begin
                                    sh_d    = HDR_B;
                                    par_d   = par_bit(HDR_B);
                                    idx_d   = 1'b1;
                                    state_d = HDR;
                                end else begin
                                    sh_d    = hold_q;
                                    par_d   = par_bit(hold_q);
                                    kind_d  = K_DATA;
                                    state_d = START;
                                end
                            end
                            K_TRL: begin
                                if (!idx_q) begin
                                    sh_d    = HDR_A;
                                    par_d   = par_bit(HDR_A);
                                    idx_d   = 1'b1;
                                    state_d = TRL;
                                end else begin
                                    kind_d  = K_DATA;
                                    state_d = IDLE;
                                end
                            end
                            default: begin
                                if (last_q) begin
                                    sh_d    = HDR_B;
                                    par_d   = par_bit(HDR_B);
                                    kind_d  = K_TRL;
                                    idx_d   = 1'b0;
                                    state_d = TRL;
                                end else if (accept) begin
                                    sh_d    = DATA_IN;
                                    par_d   = par_bit(DATA_IN);
                                    last_d  = DATA_LAST;
                                    state_d = START;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                        endcase
`else
                        if (accept) begin
                            sh_d    = DATA_IN;
                            par_d   = par_bit(DATA_IN);
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
`ifdef UART_TX_FRAME_EN
            HDR,
            TRL:     txd_d = 1'b0;
`endif
            DATA:    txd_d = sh_d[0];
            PAR:     txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    // Control registers: FSM, counters, line driver and post-reset ready enable.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            stop_q   <= 1'b0;
            txd_q    <= 1'b1;
            rdy_en_q <= 1'b0;
`ifdef UART_TX_FRAME_EN
            last_q   <= 1'b0;
            kind_q   <= K_DATA;
            idx_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            txd_q    <= txd_d;
            rdy_en_q <= 1'b1;
`ifdef UART_TX_FRAME_EN
            last_q   <= last_d;
            kind_q   <= kind_d;
            idx_q    <= idx_d;
`endif
        end
    end

    // Character datapath: shift register, parity bit and held packet character.
    always_ff @(posedge SYS_CLK) begin
        sh_q   <= sh_d;
        par_q  <= par_d;
`ifdef UART_TX_FRAME_EN
        hold_q <= hold_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations (8N1, 8E1, 8O1, 7N2, all
// CLK_DIV=4) checked cycle by cycle against a frame-level reference model,
// plus hand-written vectors and sequences with explicit bit patterns.
module tb_uart_tx_param;

    localparam int         DIV   = 4;
    localparam int         QD    = 1024;
    localparam logic [7:0] HDR_C = 8'h01;

    logic       SYS_CLK;
    logic       RST;
    logic [7:0] din [4];
    logic [3:0] vld, lst, rdy, txd, busy;

    int   checks, errors;
    logic mq [4][0:QD-1];
    int   hd [4];
    int   tl [4];
    logic mrdy [4];
    logic idle_m [4];
    logic inpkt [4];
    logic armed;

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(DIV)) u_8n1 (
        .SYS_CLK(SYS_CLK), .RST(RST), .DATA_IN(din[0]), .DATA_VALID(vld[0]), .DATA_LAST(lst[0]),
        .DATA_READY(rdy[0]), .TXD(txd[0]), .BUSY(busy[0]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_DIV(DIV)) u_8e1 (
        .SYS_CLK(SYS_CLK), .RST(RST), .DATA_IN(din[1]), .DATA_VALID(vld[1]), .DATA_LAST(lst[1]),
        .DATA_READY(rdy[1]), .TXD(txd[1]), .BUSY(busy[1]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(DIV)) u_8o1 (
        .SYS_CLK(SYS_CLK), .RST(RST), .DATA_IN(din[2]), .DATA_VALID(vld[2]), .DATA_LAST(lst[2]),
        .DATA_READY(rdy[2]), .TXD(txd[2]), .BUSY(busy[2]));
    uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLK_DIV(DIV)) u_7n2 (
        .SYS_CLK(SYS_CLK), .RST(RST), .DATA_IN(din[3][6:0]), .DATA_VALID(vld[3]), .DATA_LAST(lst[3]),
        .DATA_READY(rdy[3]), .TXD(txd[3]), .BUSY(busy[3]));

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic int db(int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int pm(int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int sb(int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic int nbits(int k);
        return 1 + db(k) + ((pm(k) != 0) ? 1 : 0) + sb(k);
    endfunction

    // Bit 'pos' of the serial frame for character d on configuration k.
    function automatic logic exp_bit(int k, logic [7:0] d, int pos);
        logic [7:0] m;
        int         ones;
        m    = d & ((8'd1 << db(k)) - 8'd1);
        ones = $countones(m);
        if (pos == 0) return 1'b0;
        if (pos <= db(k)) return m[pos-1];
        if (pm(k) != 0 && pos == db(k) + 1)
            return (pm(k) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    task automatic push_frame(int k, logic [7:0] d);
        for (int p = 0; p < nbits(k); p++) begin
            for (int r = 0; r < DIV; r++) begin
                mq[k][tl[k] % QD] = exp_bit(k, d, p);
                tl[k]++;
            end
        end
    endtask

    task automatic accept_char(int k);
`ifdef UART_TX_FRAME_EN
        if (idle_m[k]) begin
            push_frame(k, HDR_C);
            push_frame(k, ~HDR_C);
        end
        push_frame(k, din[k]);
        if (lst[k]) begin
            push_frame(k, ~HDR_C);
            push_frame(k, HDR_C);
            inpkt[k] = 1'b0;
        end else begin
            inpkt[k] = 1'b1;
        end
`else
        push_frame(k, din[k]);
`endif
    endtask

    function automatic logic open_ok(int k);
`ifdef UART_TX_FRAME_EN
        return inpkt[k];
`else
        return (k >= 0);
`endif
    endfunction

    task automatic chk(string nm, int k, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < 4; k++) begin
            hd[k]    = tl[k];
            inpkt[k] = 1'b0;
        end
        armed = 1'b0;
    endtask

    // One clock: check and pop the model at the falling edge, register accepts
    // at the rising edge, return 1 time unit after it.
    task automatic tick();
        int   sz;
        logic et;
        @(negedge SYS_CLK);
        if (RST) flush_model();
        for (int k = 0; k < 4; k++) begin
            sz        = tl[k] - hd[k];
            idle_m[k] = (sz == 0);
            et        = (sz > 0) ? mq[k][hd[k] % QD] : 1'b1;
            mrdy[k]   = armed && (sz == 0 || (sz == 1 && open_ok(k)));
            chk("model_txd", k, txd[k], et);
            chk("model_busy", k, busy[k], sz > 0);
            chk("model_ready", k, rdy[k], mrdy[k]);
            if (sz > 0) hd[k]++;
        end
        @(posedge SYS_CLK);
        if (RST) begin
            flush_model();
        end else begin
            for (int k = 0; k < 4; k++)
                if (mrdy[k] && vld[k]) accept_char(k);
            armed = 1'b1;
        end
        #1;
    endtask

    typedef struct {
        int          k;
        logic [7:0]  d;
        int          nb;
        logic [11:0] pat;
    } vec_t;

    vec_t tv [10];

    initial begin
        int         k;
        int         nb;
        logic [11:0] p;
        logic [9:0]  pf;
        logic [7:0]  fb [5];

        checks = 0;
        errors = 0;
        RST    = 1'b1;
        vld    = '0;
        lst    = '0;
        armed  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00; hd[i] = 0; tl[i] = 0; inpkt[i] = 1'b0;
            mrdy[i] = 1'b0; idle_m[i] = 1'b1;
        end

        // Vectors: {config, character, frame bits, bits in transmit order}.
        tv[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
        tv[1] = '{1, 8'hA5, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
        tv[2] = '{2, 8'hA5, 11, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}};
        tv[3] = '{0, 8'hFF, 10, {2'b00, 1'b1, 8'hFF, 1'b0}};
        tv[4] = '{1, 8'h01, 11, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}};
        tv[5] = '{2, 8'hFF, 11, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}};
        tv[6] = '{2, 8'h80, 11, {1'b0, 1'b1, 1'b0, 8'h80, 1'b0}};
        tv[7] = '{1, 8'h00, 11, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}};
        tv[8] = '{3, 8'h12, 10, {2'b00, 2'b11, 7'h12, 1'b0}};
        tv[9] = '{3, 8'h55, 10, {2'b00, 2'b11, 7'h55, 1'b0}};

        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_txd", i, txd[i], 1'b1);
            chk("rst_busy", i, busy[i], 1'b0);
            chk("rst_ready", i, rdy[i], 1'b0);
        end
        repeat (3) tick();
        RST = 1'b0;
        chk("ready_before_clock", 0, rdy[0], 1'b0);

        // Idle line for 1000 clocks.
        repeat (1000) tick();
        for (int i = 0; i < 4; i++) begin
            chk("idle_txd", i, txd[i], 1'b1);
            chk("idle_busy", i, busy[i], 1'b0);
            chk("idle_ready", i, rdy[i], 1'b1);
        end

`ifndef UART_TX_FRAME_EN
        // Single characters against hand-written bit patterns.
        for (int v = 0; v < 10; v++) begin
            k  = tv[v].k;
            nb = tv[v].nb;
            din[k] = tv[v].d;
            vld[k] = 1'b1;
            tick();
            vld[k] = 1'b0;
            for (int c = 0; c < DIV * nb; c++) begin
                if (c == 0) chk("txd_latency", k, txd[k], 1'b0);
                if (c % DIV == 2) chk("vec_bit", k, txd[k], tv[v].pat[c / DIV]);
                if (c == DIV * nb - 2) chk("vec_ready_early", k, rdy[k], 1'b0);
                if (c == DIV * nb - 1) begin
                    chk("vec_ready_last", k, rdy[k], 1'b1);
                    chk("vec_busy_last", k, busy[k], 1'b1);
                end
                tick();
            end
            chk("vec_busy_end", k, busy[k], 1'b0);
        end

        // 7N2 back-to-back with DATA_VALID held high: 0x12 then 0x7F.
        din[3] = 8'h12;
        vld[3] = 1'b1;
        tick();
        din[3] = 8'h7F;
        p = {2'b00, 2'b11, 7'h12, 1'b0};
        for (int c = 0; c < 40; c++) begin
            if (c % DIV == 2) chk("b2b_first_bit", 3, txd[3], p[c / DIV]);
            if (c == 39) chk("b2b_ready", 3, rdy[3], 1'b1);
            tick();
        end
        vld[3] = 1'b0;
        p = {2'b00, 2'b11, 7'h7F, 1'b0};
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
                chk("b2b_no_gap", 3, txd[3], 1'b0);
                chk("b2b_busy", 3, busy[3], 1'b1);
            end
            if (c % DIV == 2) chk("b2b_second_bit", 3, txd[3], p[c / DIV]);
            tick();
        end
        chk("b2b_done", 3, busy[3], 1'b0);
`else
        // Framed packet: single character 0x55 marked last.
        fb[0] = 8'h01; fb[1] = 8'hFE; fb[2] = 8'h55; fb[3] = 8'hFE; fb[4] = 8'h01;
        din[0] = 8'h55;
        lst[0] = 1'b1;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        lst[0] = 1'b0;
        for (int f = 0; f < 5; f++) begin
            pf = {1'b1, fb[f], 1'b0};
            for (int c = 0; c < 40; c++) begin
                if (c % DIV == 2) begin
                    chk("pkt_bit", f, txd[0], pf[c / DIV]);
                    chk("pkt_ready", f, rdy[0], 1'b0);
                end
                if (c == 39) chk("pkt_ready_end", f, rdy[0], 1'b0);
                tick();
            end
        end
        chk("pkt_busy_end", 0, busy[0], 1'b0);
        chk("pkt_ready_idle", 0, rdy[0], 1'b1);
`endif

        // Asynchronous reset in the third data bit of 0x00.
        din[0] = 8'h00;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        repeat (13) tick();
        chk("pre_reset_txd", 0, txd[0], 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_txd", 0, txd[0], 1'b1);
        chk("async_rst_busy", 0, busy[0], 1'b0);
        chk("async_rst_ready", 0, rdy[0], 1'b0);
        tick();
        tick();
        RST = 1'b0;
        chk("rel_ready_before_clock", 0, rdy[0], 1'b0);
        tick();
        chk("rel_ready", 0, rdy[0], 1'b1);
        chk("rel_txd", 0, txd[0], 1'b1);
        chk("rel_busy", 0, busy[0], 1'b0);
        repeat (60) tick();

        // Randomised traffic on all four configurations.
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < 4; i++) begin
                vld[i] = 1'($urandom_range(0, 1));
                din[i] = 8'($urandom);
                lst[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        vld = '0;
        repeat (300) tick();
        for (int i = 0; i < 4; i++) begin
            chk("drain_busy", i, busy[i], 1'b0);
            chk("drain_txd", i, txd[i], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
